piece_dropper: RTL and testbench



---
 rtl/piece_dropper.sv | 129 ++++++++++++
 tb/tb_piece_dropper.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_dropper.sv
// piece_dropper: owns the game board and performs piece drops. A request
// (column, player) is accepted in IDLE. The column is scanned bottom-up one
// cell per cycle, the piece is written into the lowest empty cell, and a
// one-cycle done pulse reports the landing coordinates.
module piece_dropper #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_drop_valid,
  output logic                     o_drop_ready,
  input  logic [2:0]               i_drop_col,
  input  logic [1:0]               i_drop_player,
  output logic                     o_done,
  output logic                     o_done_ok,
  output logic [2:0]               o_done_row,
  output logic [2:0]               o_done_col,
  output logic [6:0]               o_piece_count,
  output logic                     o_board_full,
  output logic [ROWS*COLS*2-1:0]   o_board_out
);

  localparam int unsigned NCells = ROWS * COLS;
  localparam int unsigned IdxW   = (NCells > 1) ? $clog2(NCells) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StWrite, StDone} state_e;

  state_e                  r_state;
  logic [NCells-1:0][1:0]  r_board;
  logic [6:0]              r_count;
  logic [2:0]              r_col;
  logic [1:0]              r_player;
  logic [2:0]              r_scan_row;
  logic                    r_done;
  logic                    r_done_ok;
  logic [2:0]              r_done_row;
  logic [2:0]              r_done_col;

  logic [IdxW-1:0]         w_idx;
  logic [1:0]              w_cell;
  logic                    w_illegal;
  logic                    w_last_row;
  logic                    w_full;

  // Flat cell index of the cell currently being scanned or written.
  assign w_idx      = IdxW'(32'(r_scan_row) * COLS + 32'(r_col));
  assign w_cell     = r_board[w_idx];
  assign w_illegal  = (32'(i_drop_col) >= COLS) || (i_drop_player == 2'b00) ||
                      (i_drop_player == 2'b11);
  assign w_last_row = (r_scan_row == 3'(ROWS - 1));
  assign w_full     = (r_count == 7'(NCells));

  assign o_drop_ready  = (r_state == StIdle) && !i_clear;
  assign o_done        = r_done;
  assign o_done_ok     = r_done_ok;
  assign o_done_row    = r_done_row;
  assign o_done_col    = r_done_col;
  assign o_piece_count = r_count;
  assign o_board_full  = w_full;
  assign o_board_out   = r_board;

  // Drop FSM: accept, scan bottom-up, write, then pulse done for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_board    <= '0;
      r_count    <= '0;
      r_col      <= '0;
      r_player   <= '0;
      r_scan_row <= '0;
      r_done     <= 1'b0;
      r_done_ok  <= 1'b0;
      r_done_row <= '0;
      r_done_col <= '0;
    end else if (i_clear) begin
      // Abort: done_row/done_col/done_ok intentionally keep their values.
      r_state <= StIdle;
      r_board <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_drop_valid) begin
            r_col      <= i_drop_col;
            r_player   <= i_drop_player;
            r_scan_row <= '0;
            r_done_col <= i_drop_col;
            if (w_illegal) begin
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_done_ok <= 1'b0;
            end else begin
              r_state <= StScan;
            end
          end
        end
        StScan: begin
          if (w_cell == 2'b00) begin
            r_state <= StWrite;
          end else if (w_last_row) begin
            r_state   <= StDone;
            r_done    <= 1'b1;
            r_done_ok <= 1'b0;
          end else begin
            r_scan_row <= r_scan_row + 3'd1;
          end
        end
        StWrite: begin
          r_board[w_idx] <= r_player;
          if (!w_full) begin
            r_count <= r_count + 7'd1;
          end
          r_done_row <= r_scan_row;
          r_done_ok  <= 1'b1;
          r_done     <= 1'b1;
          r_state    <= StDone;
        end
        StDone: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piece_dropper.sv
// Scoreboard bench for piece_dropper on a non-square 8x7 board. Expected
// completions are pushed at acceptance; a monitor checks each done pulse.
module tb_piece_dropper;

  localparam int ROWS   = 8;
  localparam int COLS   = 7;
  localparam int NCELLS = ROWS * COLS;
  localparam int BW     = NCELLS * 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          drop_valid = 1'b0;
  logic [2:0]    drop_col = '0;
  logic [1:0]    drop_player = '0;
  logic          drop_ready;
  logic          done;
  logic          done_ok;
  logic [2:0]    done_row;
  logic [2:0]    done_col;
  logic [6:0]    piece_count;
  logic          board_full;
  logic [BW-1:0] board_out;

  piece_dropper #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (clear),
    .i_drop_valid  (drop_valid),
    .o_drop_ready  (drop_ready),
    .i_drop_col    (drop_col),
    .i_drop_player (drop_player),
    .o_done        (done),
    .o_done_ok     (done_ok),
    .o_done_row    (done_row),
    .o_done_col    (done_col),
    .o_piece_count (piece_count),
    .o_board_full  (board_full),
    .o_board_out   (board_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          ok;
    logic [2:0]    row;
    logic [2:0]    col;
    int            cyc;
    int            count;
    logic [BW-1:0] board;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: board as a 2-D array plus per-column heights.
  logic [1:0] m_cell[ROWS][COLS];
  int         m_h[COLS];
  int         m_count;
  logic [2:0] m_last_row;
  logic       m_last_ok;
  logic [1:0] alt_pl;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic [BW-1:0] pack_board();
    logic [BW-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[(r * COLS + c) * 2 +: 2] = m_cell[r][c];
    return v;
  endfunction

  task automatic m_reset(input bit full_reset);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_cell[r][c] = 2'b00;
    for (int c = 0; c < COLS; c++) m_h[c] = 0;
    m_count = 0;
    if (full_reset) begin
      m_last_row = '0;
      m_last_ok  = 1'b0;
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        fail_now("unexpected_done", $sformatf("got done=1 col=%0d, expected no pulse", done_col));
      end else begin
        e = sbq.pop_front();
        chk("done_ok", 128'(done_ok), 128'(e.ok));
        chk("done_row", 128'(done_row), 128'(e.row));
        chk("done_col", 128'(done_col), 128'(e.col));
        chk("done_cycle", 128'(cyc), 128'(e.cyc));
        chk("piece_count", 128'(piece_count), 128'(e.count));
        chk("board_full", 128'(board_full), 128'(e.count == NCELLS));
        chk("board_out", 128'(board_out), 128'(e.board));
      end
    end
  end

  function automatic logic [1:0] rand_player();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 2'b00;
    if (r == 1) return 2'b11;
    return (r % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic wait_ready(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (drop_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("ready_timeout", "got drop_ready=0 for 50 cycles, expected 1");
  endtask

  task automatic do_drop(input logic [2:0] col, input logic [1:0] pl, input bit noise);
    exp_t e;
    bit   got;
    bit   illegal;
    int   c;
    int   lat;
    wait_ready(got);
    if (!got) return;
    drop_valid  = 1'b1;
    drop_col    = col;
    drop_player = pl;
    @(posedge clk);
    #1;
    c       = int'(col);
    illegal = (c >= COLS) || (pl == 2'b00) || (pl == 2'b11);
    e.col   = col;
    if (illegal) begin
      e.ok = 1'b0;
      e.row = m_last_row;
      lat = 0;
    end else if (m_h[c] == ROWS) begin
      e.ok = 1'b0;
      e.row = m_last_row;
      lat = ROWS;
    end else begin
      e.ok = 1'b1;
      e.row = 3'(m_h[c]);
      lat = m_h[c] + 2;
      m_cell[m_h[c]][c] = pl;
      m_h[c]++;
      m_count++;
      m_last_row = e.row;
    end
    m_last_ok = e.ok;
    e.cyc   = cyc + lat;
    e.count = m_count;
    e.board = pack_board();
    sbq.push_back(e);
    if (noise && !illegal) begin
      // A busy block must ignore this second request.
      drop_col    = 3'($urandom_range(0, 7));
      drop_player = rand_player();
      @(posedge clk);
      #1;
    end
    drop_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (sbq.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      fail_now("done_timeout", "got no done pulse within 40 cycles, expected one");
      sbq.delete();
      return;
    end
    @(negedge clk);
    chk("ready_after_done", 128'(drop_ready), 128'(1));
  endtask

  task automatic abort_with_clear(input logic [2:0] col, input logic [1:0] pl);
    bit got;
    wait_ready(got);
    if (!got) return;
    drop_valid  = 1'b1;
    drop_col    = col;
    drop_player = pl;
    @(posedge clk);
    #1;
    drop_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear       = 1'b1;
    drop_valid  = 1'b1;
    drop_col    = 3'd1;
    drop_player = 2'b01;
    #1;
    chk("ready_during_clear", 128'(drop_ready), 128'(0));
    @(posedge clk);
    #1;
    chk("clear_board", 128'(board_out), 128'(0));
    chk("clear_count", 128'(piece_count), 128'(0));
    chk("clear_done", 128'(done), 128'(0));
    chk("clear_done_ok", 128'(done_ok), 128'(m_last_ok));
    chk("clear_done_row", 128'(done_row), 128'(m_last_row));
    clear      = 1'b0;
    drop_valid = 1'b0;
    m_reset(1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("ready_after_clear", 128'(drop_ready), 128'(1));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_board"}, 128'(board_out), 128'(0));
    chk({tag, "_count"}, 128'(piece_count), 128'(0));
    chk({tag, "_full"}, 128'(board_full), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_done_ok"}, 128'(done_ok), 128'(0));
    chk({tag, "_done_row"}, 128'(done_row), 128'(0));
    chk({tag, "_done_col"}, 128'(done_col), 128'(0));
    chk({tag, "_ready"}, 128'(drop_ready), 128'(1));
  endtask

  initial begin
    bit got;
    m_reset(1'b1);
    alt_pl = 2'b01;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Landing on an empty column, then stacking to row 3.
    do_drop(3'd3, 2'b01, 1'b0);
    do_drop(3'd3, 2'b10, 1'b0);
    do_drop(3'd3, 2'b01, 1'b0);
    do_drop(3'd3, 2'b10, 1'b1);

    // Illegal column and player codes.
    do_drop(3'd7, 2'b01, 1'b0);
    do_drop(3'd2, 2'b00, 1'b0);
    do_drop(3'd2, 2'b11, 1'b0);

    // Fill column 0, then one more into the full column.
    for (int i = 0; i < ROWS; i++) begin
      do_drop(3'd0, alt_pl, 1'b0);
      alt_pl = ~alt_pl;
    end
    do_drop(3'd0, 2'b01, 1'b0);

    // Clear during a scan of a 5-deep column.
    for (int i = 0; i < 5; i++) do_drop(3'd5, 2'b10, 1'b0);
    abort_with_clear(3'd5, 2'b01);

    for (int i = 0; i < 120; i++)
      do_drop(3'($urandom_range(0, 7)), rand_player(), 1'($urandom_range(0, 1)));

    // Fill the whole board with alternating players.
    for (int c = 0; c < COLS; c++) begin
      while (m_h[c] < ROWS) begin
        do_drop(3'(c), alt_pl, 1'b0);
        alt_pl = ~alt_pl;
      end
    end
    chk("filled_full", 128'(board_full), 128'(1));
    chk("filled_count", 128'(piece_count), 128'(NCELLS));
    do_drop(3'd4, 2'b10, 1'b0);

    // Asynchronous reset in the middle of a scan.
    wait_ready(got);
    if (got) begin
      drop_valid  = 1'b1;
      drop_col    = 3'd2;
      drop_player = 2'b01;
      @(posedge clk);
      #1;
      drop_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      m_reset(1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
    end
    do_drop(3'd3, 2'b01, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
